// File: rtl/cache_ctrl_if.sv
// CPU and next-level bus bundle for the L1 cache controller.
// The controller takes the slave view; the CPU/memory side takes master.
interface cache_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic [DATA_WIDTH-1:0] cpu_rdata;
  logic                  cpu_ready;
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  mem_rdata, mem_ack,
    output cpu_rdata, cpu_ready,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, one-word-line L1 controller; write-through, no
// write-allocate, tag/valid store local, data held in cache_block.
module cache_ctrl #(
  parameter int NUM_OF_ENTRY = 1024,
  parameter int ENTRY_WIDTH  = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  cache_ctrl_if.slave            bus,
  input  logic                   inv,
  output logic [ENTRY_WIDTH-1:0] blk_index,
  output logic                   blk_we,
  output logic [DATA_WIDTH-1:0]  blk_din,
  input  logic [DATA_WIDTH-1:0]  blk_dout,
  output logic [CNT_WIDTH-1:0]   hit_cnt,
  output logic [CNT_WIDTH-1:0]   miss_cnt
);

  localparam int TW = ADDR_WIDTH - ENTRY_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESP
  } state_t;

  state_t state, nxt;

  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic [DATA_WIDTH-1:0]  fill_q;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [NUM_OF_ENTRY-1:0] valid;
  logic [TW-1:0]          tag [NUM_OF_ENTRY];

  logic [ENTRY_WIDTH-1:0] idx;
  logic [TW-1:0]          rtag;
  logic                   hit;
  logic                   take;

  assign idx  = r_addr[ENTRY_WIDTH-1:0];
  assign rtag = r_addr[ADDR_WIDTH-1:ENTRY_WIDTH];
  assign hit  = valid[idx] && (tag[idx] == rtag);
  assign take = (state == IDLE) && !inv && bus.cpu_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (take) nxt = LOOKUP;
      LOOKUP: nxt = r_we ? MEM_WR : (hit ? RESP : MEM_RD);
      MEM_RD: if (bus.mem_ack) nxt = FILL;
      FILL:   nxt = RESP;
      MEM_WR: if (bus.mem_ack) nxt = RESP;
      RESP:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Array-facing outputs come only from registers: cache_block
  // writes are level-sensitive, so no cpu_* input may reach blk_we.
  assign blk_index = idx;
  assign blk_we    = ((state == LOOKUP) && r_we && hit)
                   || (state == FILL);
  assign blk_din   = (state == FILL) ? fill_q : r_wdata;

  assign bus.mem_req   = (state == MEM_RD) || (state == MEM_WR);
  assign bus.mem_we    = (state == MEM_WR);
  assign bus.mem_addr  = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.cpu_ready = (state == RESP);
  assign bus.cpu_rdata = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      fill_q   <= '0;
      rdata_q  <= '0;
      valid    <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (take) begin
        r_we    <= bus.cpu_we;
        r_addr  <= bus.cpu_addr;
        r_wdata <= bus.cpu_wdata;
      end
      if ((state == MEM_RD) && bus.mem_ack)
        fill_q <= bus.mem_rdata;
      if ((state == LOOKUP) && !r_we && hit)
        rdata_q <= blk_dout;
      else if (state == FILL)
        rdata_q <= fill_q;
      if (state == LOOKUP) begin
        if (hit) hit_cnt  <= hit_cnt + CNT_WIDTH'(1);
        else     miss_cnt <= miss_cnt + CNT_WIDTH'(1);
      end
      if ((state == IDLE) && inv)
        valid <= '0;
      else if (state == FILL)
        valid[idx] <= 1'b1;
    end
  end

  // Tags need no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == FILL) tag[idx] <= rtag;
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed testbench for cache_ctrl with a behavioural cache_block
// array and a scripted next-level memory responder.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inv;
  logic [9:0]  blk_index;
  logic        blk_we;
  logic [31:0] blk_din;
  logic [31:0] blk_dout;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  cache_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  cache_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .inv       (inv),
    .blk_index (blk_index),
    .blk_we    (blk_we),
    .blk_din   (blk_din),
    .blk_dout  (blk_dout),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  logic [31:0] arr [1024];
  assign blk_dout = arr[blk_index];
  always @(posedge clk) if (blk_we) arr[blk_index] <= blk_din;

  int errors = 0;
  int checks = 0;

  int          r_ready, r_mreq_n, r_blkwe_n, r_blkwe_cyc, r_ack_cyc;
  logic [31:0] r_rdata, r_maddr, r_mwdata, r_blk_din;
  logic        r_mwe;
  logic [9:0]  r_blk_idx;

  // Issue one request; cycle 0 is the IDLE cycle that samples cpu_req.
  // The memory acks after dly cycles of mem_req.
  task automatic run_op(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int dly,
                        input logic [31:0] mrd, input bit with_inv);
    int nreq;
    @(posedge clk); #1;
    r_ready = -1; r_mreq_n = 0; r_blkwe_n = 0;
    r_blkwe_cyc = -1; r_ack_cyc = -1;
    bus.cpu_req = 1'b1; bus.cpu_we = we;
    bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    if (with_inv) begin
      inv = 1'b1;
      @(posedge clk); #1;
      inv = 1'b0;
    end
    @(posedge clk); #1;
    bus.cpu_req = 1'b0; bus.cpu_we = ~we;
    bus.cpu_addr = ~addr; bus.cpu_wdata = ~wdata;
    nreq = 0;
    for (int cyc = 1; cyc < 60; cyc++) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        r_mreq_n++;
        r_maddr = bus.mem_addr; r_mwe = bus.mem_we;
        r_mwdata = bus.mem_wdata;
        if (nreq == dly) begin
          bus.mem_ack = 1'b1; bus.mem_rdata = mrd; r_ack_cyc = cyc;
        end
        nreq++;
      end
      if (blk_we) begin
        r_blkwe_n++; r_blkwe_cyc = cyc;
        r_blk_idx = blk_index; r_blk_din = blk_din;
      end
      if (bus.cpu_ready) begin
        r_ready = cyc; r_rdata = bus.cpu_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; inv = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.cpu_ready !== 1'b0 || bus.mem_req !== 1'b0 || blk_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: ready=%b mreq=%b bwe=%b req 0 0 0",
               bus.cpu_ready, bus.mem_req, blk_we);
    end
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d req 0 0", hit_cnt, miss_cnt);
    end
    checks++;
    if (bus.cpu_rdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h maddr=%h mwdata=%h req 0",
               bus.cpu_rdata, bus.mem_addr, bus.mem_wdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_read_miss();
    run_op(1'b0, 32'h5, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
    checks++;
    if (r_mreq_n !== 4 || r_maddr !== 32'h5 || r_mwe !== 1'b0) begin
      errors++;
      $display("FAIL rmiss_mem: n=%0d addr=%h we=%b req 4 5 0",
               r_mreq_n, r_maddr, r_mwe);
    end
    checks++;
    if (r_blkwe_n !== 1 || r_blkwe_cyc !== 6 || r_blk_idx !== 10'd5
        || r_blk_din !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL rmiss_fill: n=%0d cyc=%0d idx=%0d din=%h req 1 6 5 deadbeef",
               r_blkwe_n, r_blkwe_cyc, r_blk_idx, r_blk_din);
    end
    checks++;
    if (r_ready !== 7 || r_rdata !== 32'hDEAD_BEEF || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rmiss_resp: lat=%0d rdata=%h miss=%0d req 7 deadbeef 1",
               r_ready, r_rdata, miss_cnt);
    end
  endtask

  task automatic test_read_hit();
    run_op(1'b0, 32'h5, 32'h0, 0, 32'h0, 1'b0);
    checks++;
    if (r_ready !== 2 || r_rdata !== 32'hDEAD_BEEF || r_mreq_n !== 0) begin
      errors++;
      $display("FAIL rhit: lat=%0d rdata=%h mreq=%0d req 2 deadbeef 0",
               r_ready, r_rdata, r_mreq_n);
    end
    checks++;
    if (hit_cnt !== 16'd1 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL rhit_cnt: hit=%0d miss=%0d req 1 1", hit_cnt, miss_cnt);
    end
  endtask

  task automatic test_write_hit();
    run_op(1'b1, 32'h5, 32'h1234_5678, 0, 32'h0, 1'b0);
    checks++;
    if (r_blkwe_n !== 1 || r_blkwe_cyc !== 1 || r_blk_din !== 32'h1234_5678) begin
      errors++;
      $display("FAIL whit_blk: n=%0d cyc=%0d din=%h req 1 1 12345678",
               r_blkwe_n, r_blkwe_cyc, r_blk_din);
    end
    checks++;
    if (r_mwe !== 1'b1 || r_maddr !== 32'h5 || r_mwdata !== 32'h1234_5678
        || r_ready !== 3) begin
      errors++;
      $display("FAIL whit_mem: we=%b addr=%h data=%h lat=%0d req 1 5 12345678 3",
               r_mwe, r_maddr, r_mwdata, r_ready);
    end
    run_op(1'b0, 32'h5, 32'h0, 0, 32'h0, 1'b0);
    checks++;
    if (r_ready !== 2 || r_rdata !== 32'h1234_5678 || hit_cnt !== 16'd3) begin
      errors++;
      $display("FAIL whit_read: lat=%0d rdata=%h hit=%0d req 2 12345678 3",
               r_ready, r_rdata, hit_cnt);
    end
  endtask

  task automatic test_conflict();
    run_op(1'b0, 32'h405, 32'h0, 1, 32'hCAFE_F00D, 1'b0);
    checks++;
    if (r_ready !== 5 || r_rdata !== 32'hCAFE_F00D || r_maddr !== 32'h405
        || miss_cnt !== 16'd2) begin
      errors++;
      $display("FAIL conf_fill: lat=%0d rdata=%h addr=%h miss=%0d req 5 cafef00d 405 2",
               r_ready, r_rdata, r_maddr, miss_cnt);
    end
    run_op(1'b0, 32'h5, 32'h0, 0, 32'h1234_5678, 1'b0);
    checks++;
    if (r_mreq_n !== 1 || r_ready !== 4 || r_rdata !== 32'h1234_5678
        || miss_cnt !== 16'd3) begin
      errors++;
      $display("FAIL conf_evict: mreq=%0d lat=%0d rdata=%h miss=%0d req 1 4 12345678 3",
               r_mreq_n, r_ready, r_rdata, miss_cnt);
    end
  endtask

  task automatic test_write_miss();
    run_op(1'b1, 32'h9, 32'hA5A5_A5A5, 2, 32'h0, 1'b0);
    checks++;
    if (r_blkwe_n !== 0 || r_mwe !== 1'b1 || r_mwdata !== 32'hA5A5_A5A5
        || r_ready !== 5 || miss_cnt !== 16'd4) begin
      errors++;
      $display("FAIL wmiss: bwe=%0d we=%b data=%h lat=%0d miss=%0d req 0 1 a5a5a5a5 5 4",
               r_blkwe_n, r_mwe, r_mwdata, r_ready, miss_cnt);
    end
    run_op(1'b0, 32'h9, 32'h0, 0, 32'hA5A5_A5A5, 1'b0);
    checks++;
    if (r_mreq_n !== 1 || r_ready !== 4 || miss_cnt !== 16'd5) begin
      errors++;
      $display("FAIL wmiss_noalloc: mreq=%0d lat=%0d miss=%0d req 1 4 5",
               r_mreq_n, r_ready, miss_cnt);
    end
  endtask

  task automatic test_inv();
    run_op(1'b0, 32'h5, 32'h0, 0, 32'h1234_5678, 1'b1);
    checks++;
    if (r_mreq_n !== 1 || r_ready !== 4 || r_rdata !== 32'h1234_5678
        || miss_cnt !== 16'd6 || hit_cnt !== 16'd3) begin
      errors++;
      $display("FAIL inv_req: mreq=%0d lat=%0d rdata=%h miss=%0d hit=%0d req 1 4 12345678 6 3",
               r_mreq_n, r_ready, r_rdata, miss_cnt, hit_cnt);
    end
    run_op(1'b0, 32'h9, 32'h0, 0, 32'hA5A5_A5A5, 1'b0);
    checks++;
    if (r_mreq_n !== 1 || miss_cnt !== 16'd7) begin
      errors++;
      $display("FAIL inv_all: mreq=%0d miss=%0d req 1 7", r_mreq_n, miss_cnt);
    end
  endtask

  task automatic test_reset_midop();
    @(posedge clk); #1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h20;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL midop_req: mreq=%b req 1", bus.mem_req);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b0 || blk_we !== 1'b0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL midop_abort: mreq=%b bwe=%b miss=%0d req 0 0 0",
               bus.mem_req, blk_we, miss_cnt);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(1'b0, 32'h20, 32'h0, 0, 32'h0000_0077, 1'b0);
    checks++;
    if (r_mreq_n !== 1 || r_ready !== 4 || r_rdata !== 32'h77
        || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL midop_after: mreq=%0d lat=%0d rdata=%h miss=%0d req 1 4 77 1",
               r_mreq_n, r_ready, r_rdata, miss_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_conflict();
    test_write_miss();
    test_inv();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
